// File: rtl/ft8_tone_scheduler.sv
// ---------------------------------------------------------------------------
// ft8_tone_scheduler
// Buffers 3-bit 8-FSK symbols from the FT8 modulator in a FIFO and replays
// them at a fixed symbol rate. Each tone is held for SYMBOL_CYCLES clocks and
// is presented to the NCO as a registered tuning word
// ftw = BASE_FTW + tone * TONE_STEP_FTW (wrapping modulo 2^FTW_W).
//
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   symbol_in      : symbol from the modulator, written when symbol_valid
//   symbol_valid   : write strobe, one symbol per cycle
//   msg_complete   : end-of-message marker from the modulator
//   clr_flags      : synchronous clear of the overflow / underrun flags
//   ftw_out        : NCO tuning word (registered)
//   tone_idx       : tone currently transmitted
//   tone_strobe    : one-cycle pulse on the first cycle of every tone
//   tx_en          : high while a tone is being sent
//   tx_done        : one-cycle pulse after the last tone of a frame
//   overflow       : sticky, a write was attempted while the FIFO was full
//   underrun       : sticky, FIFO ran dry mid-frame without msg_complete
//   fifo_count     : current FIFO occupancy
// ---------------------------------------------------------------------------
module ft8_tone_scheduler #(
    parameter int               FIFO_DEPTH      = 128,
    parameter int               SYMBOLS_PER_MSG = 79,
    parameter int               SYMBOL_CYCLES   = 16,
    parameter int               FTW_W           = 32,
    parameter logic [FTW_W-1:0] BASE_FTW        = 32'h0100_0000,
    parameter logic [FTW_W-1:0] TONE_STEP_FTW   = 32'h0000_0100
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2:0]                  symbol_in,
    input  logic                        symbol_valid,
    input  logic                        msg_complete,
    input  logic                        clr_flags,
    output logic [FTW_W-1:0]            ftw_out,
    output logic [2:0]                  tone_idx,
    output logic                        tone_strobe,
    output logic                        tx_en,
    output logic                        tx_done,
    output logic                        overflow,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CYC_W = $clog2(SYMBOL_CYCLES);
    localparam int SYM_W = $clog2(SYMBOLS_PER_MSG + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] SPM_CNT_C  = CNT_W'(SYMBOLS_PER_MSG);
    localparam logic [CYC_W-1:0] CYC_LAST_C = CYC_W'(SYMBOL_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ZERO_C = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0] CYC_ONE_C  = CYC_W'(1);
    localparam logic [SYM_W-1:0] SPM_SYM_C  = SYM_W'(SYMBOLS_PER_MSG);
    localparam logic [SYM_W-1:0] SYM_ZERO_C = {SYM_W{1'b0}};
    localparam logic [SYM_W-1:0] SYM_ONE_C  = SYM_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Tuning word of a tone; the product and sum wrap modulo 2^FTW_W.
    function automatic logic [FTW_W-1:0] ftw_of(input logic [2:0] sym);
        ftw_of = BASE_FTW + (FTW_W'(sym) * TONE_STEP_FTW);
    endfunction

    state_e           state_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [2:0]       mem_q [FIFO_DEPTH];
    logic             msg_seen_q, msg_seen_d;
    logic [CYC_W-1:0] cyc_cnt_q;
    logic [SYM_W-1:0] sym_cnt_q;

    logic       push_s, pop_s, ov_set_s;
    logic       start_s, end_frame_s, starve_s, next_s;
    logic [2:0] head_s;

    // A write at full is dropped even if a pop happens in the same cycle:
    // push/pop decisions look only at the registered count.
    assign push_s     = symbol_valid & (count_q != DEPTH_C);
    assign ov_set_s   = symbol_valid & (count_q == DEPTH_C);
    assign pop_s      = start_s | next_s;
    assign head_s     = mem_q[rd_ptr_q];
    assign fifo_count = count_q;

    // Frame sequencing decisions for the current cycle.
    always_comb begin
        start_s     = 1'b0;
        end_frame_s = 1'b0;
        starve_s    = 1'b0;
        next_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((count_q >= SPM_CNT_C) || (msg_seen_q && (count_q != CNT_ZERO_C))) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_TX: begin
                if (cyc_cnt_q == CYC_LAST_C) begin
                    if (sym_cnt_q == SPM_SYM_C) begin
                        end_frame_s = 1'b1;
                    end else if ((count_q == CNT_ZERO_C) && msg_seen_q) begin
                        end_frame_s = 1'b1;
                    end else if (count_q == CNT_ZERO_C) begin
                        starve_s = 1'b1;
                    end else begin
                        next_s = 1'b1;
                    end
                end else begin
                    next_s = 1'b0;
                end
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // FIFO occupancy next state.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase
    end

    // msg_complete always wins over the clear at frame start / DONE.
    always_comb begin
        if (msg_complete) begin
            msg_seen_d = 1'b1;
        end else if (start_s || (state_q == ST_DONE)) begin
            msg_seen_d = 1'b0;
        end else begin
            msg_seen_d = msg_seen_q;
        end
    end

    // Symbol storage; contents are don't-care after reset since pointers clear.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= symbol_in;
        end
    end

    // FIFO pointers, occupancy and end-of-message tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= CNT_ZERO_C;
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            msg_seen_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            msg_seen_q <= msg_seen_d;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE_C;
            end
        end
    end

    // Transmit FSM with registered NCO / status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ftw_out     <= BASE_FTW;
            tone_idx    <= 3'd0;
            tone_strobe <= 1'b0;
            tx_en       <= 1'b0;
            tx_done     <= 1'b0;
            cyc_cnt_q   <= CYC_ZERO_C;
            sym_cnt_q   <= SYM_ZERO_C;
        end else begin
            tone_strobe <= 1'b0;
            tx_done     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q     <= ST_TX;
                        tone_idx    <= head_s;
                        ftw_out     <= ftw_of(head_s);
                        tx_en       <= 1'b1;
                        tone_strobe <= 1'b1;
                        sym_cnt_q   <= SYM_ONE_C;
                        cyc_cnt_q   <= CYC_ZERO_C;
                    end
                end
                ST_TX: begin
                    if (end_frame_s) begin
                        state_q  <= ST_DONE;
                        tx_en    <= 1'b0;
                        ftw_out  <= BASE_FTW;
                        tone_idx <= 3'd0;
                        tx_done  <= 1'b1;
                    end else if (starve_s) begin
                        // Aborted frame: no tx_done, the underrun flag reports it.
                        state_q <= ST_IDLE;
                        tx_en   <= 1'b0;
                        ftw_out <= BASE_FTW;
                    end else if (next_s) begin
                        tone_idx    <= head_s;
                        ftw_out     <= ftw_of(head_s);
                        tone_strobe <= 1'b1;
                        sym_cnt_q   <= sym_cnt_q + SYM_ONE_C;
                        cyc_cnt_q   <= CYC_ZERO_C;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + CYC_ONE_C;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a set condition beats clr_flags in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (ov_set_s) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (starve_s) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ft8_tone_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ft8_tone_scheduler
// Directed bench for ft8_tone_scheduler. Two instances share clk/rst_n:
//   u_dut_a : FIFO 128, 79 symbols/frame, 4 clocks/symbol, default tuning words
//   u_dut_b : FIFO 4, 4 symbols/frame, 4 clocks/symbol, BASE_FTW=FFFF_FFF0,
//             TONE_STEP_FTW=8 (tuning word wraps for high tones)
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ft8_tone_scheduler;

    localparam logic [31:0] A_BASE = 32'h0100_0000;
    localparam logic [31:0] A_STEP = 32'h0000_0100;
    localparam logic [31:0] B_BASE = 32'hFFFF_FFF0;

    logic clk = 1'b0;
    logic rst_n;

    logic [2:0]  a_sym, b_sym;
    logic        a_vld, a_msg, a_clr, b_vld, b_msg, b_clr;
    logic [31:0] a_ftw, b_ftw;
    logic [2:0]  a_tone, b_tone;
    logic        a_stb, a_txen, a_done, a_ov, a_ur;
    logic        b_stb, b_txen, b_done, b_ov, b_ur;
    logic [7:0]  a_cnt;
    logic [2:0]  b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor selection: 0 watches u_dut_a, 1 watches u_dut_b.
    logic        sel;
    logic        mon_stb, mon_done;
    logic [2:0]  mon_tone;
    logic [31:0] mon_ftw;
    assign mon_stb  = sel ? b_stb  : a_stb;
    assign mon_done = sel ? b_done : a_done;
    assign mon_tone = sel ? b_tone : a_tone;
    assign mon_ftw  = sel ? b_ftw  : a_ftw;

    int          ntone;
    int          done_at;
    logic [2:0]  tones [128];
    logic [31:0] ftws  [128];
    int          stb_t [128];

    always #5 clk = ~clk;

    ft8_tone_scheduler #(
        .FIFO_DEPTH(128), .SYMBOLS_PER_MSG(79), .SYMBOL_CYCLES(4), .FTW_W(32),
        .BASE_FTW(32'h0100_0000), .TONE_STEP_FTW(32'h0000_0100)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .symbol_in(a_sym), .symbol_valid(a_vld),
        .msg_complete(a_msg), .clr_flags(a_clr), .ftw_out(a_ftw), .tone_idx(a_tone),
        .tone_strobe(a_stb), .tx_en(a_txen), .tx_done(a_done), .overflow(a_ov),
        .underrun(a_ur), .fifo_count(a_cnt)
    );

    ft8_tone_scheduler #(
        .FIFO_DEPTH(4), .SYMBOLS_PER_MSG(4), .SYMBOL_CYCLES(4), .FTW_W(32),
        .BASE_FTW(32'hFFFF_FFF0), .TONE_STEP_FTW(32'h0000_0008)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .symbol_in(b_sym), .symbol_valid(b_vld),
        .msg_complete(b_msg), .clr_flags(b_clr), .ftw_out(b_ftw), .tone_idx(b_tone),
        .tone_strobe(b_stb), .tx_en(b_txen), .tx_done(b_done), .overflow(b_ov),
        .underrun(b_ur), .fifo_count(b_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic a_write(input logic [2:0] s);
        a_sym = s;
        a_vld = 1'b1;
        @(negedge clk);
        a_vld = 1'b0;
    endtask

    task automatic b_write(input logic [2:0] s);
        b_sym = s;
        b_vld = 1'b1;
        @(negedge clk);
        b_vld = 1'b0;
    endtask

    // Record strobed tones for up to max_cyc cycles; stop at tx_done.
    task automatic watch(input int max_cyc);
        ntone   = 0;
        done_at = -1;
        for (int t = 0; t < max_cyc; t++) begin
            @(negedge clk);
            if (mon_stb && (ntone < 128)) begin
                tones[ntone] = mon_tone;
                ftws[ntone]  = mon_ftw;
                stb_t[ntone] = t;
                ntone++;
            end
            if (mon_done) begin
                done_at = t;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 1'b0;
        a_sym = 3'd0; a_vld = 1'b0; a_msg = 1'b0; a_clr = 1'b0;
        b_sym = 3'd0; b_vld = 1'b0; b_msg = 1'b0; b_clr = 1'b0;
        repeat (3) @(negedge clk);

        // Power-on reset values
        check_eq("rst_a_cnt",  32'(a_cnt),  32'd0);
        check_eq("rst_a_ftw",  a_ftw,       A_BASE);
        check_eq("rst_a_tone", 32'(a_tone), 32'd0);
        check_eq("rst_a_txen", 32'(a_txen), 32'd0);
        check_eq("rst_a_stb",  32'(a_stb),  32'd0);
        check_eq("rst_a_done", 32'(a_done), 32'd0);
        check_eq("rst_a_ov",   32'(a_ov),   32'd0);
        check_eq("rst_a_ur",   32'(a_ur),   32'd0);
        check_eq("rst_b_ftw",  b_ftw,       B_BASE);
        check_eq("rst_b_cnt",  32'(b_cnt),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T2: full 79-symbol frame
        for (int i = 0; i < 79; i++) a_write(3'(i % 8));
        check_eq("t2_cnt_full", 32'(a_cnt),  32'd79);
        check_eq("t2_txen_pre", 32'(a_txen), 32'd0);
        sel = 1'b0;
        watch(400);
        check_eq("t2_ntone",   32'(ntone),   32'd79);
        check_eq("t2_done_at", 32'(done_at), 32'd316);
        for (int i = 0; i < ntone; i++) begin
            check_eq("t2_tone",  32'(tones[i]), 32'(i % 8));
            check_eq("t2_ftw",   ftws[i],       A_BASE + 32'(i % 8) * A_STEP);
            check_eq("t2_space", 32'(stb_t[i]), 32'(4 * i));
        end
        check_eq("t2_txen_end", 32'(a_txen), 32'd0);
        check_eq("t2_ftw_end",  a_ftw,       A_BASE);
        check_eq("t2_tone_end", 32'(a_tone), 32'd0);
        check_eq("t2_ur",       32'(a_ur),   32'd0);
        check_eq("t2_cnt_end",  32'(a_cnt),  32'd0);

        // T3: short frame 5,2,7 closed by msg_complete
        a_write(3'd5); a_write(3'd2); a_write(3'd7);
        a_msg = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a_msg = 1'b0;
        check_eq("t3_txen",  32'(a_txen), 32'd1);
        check_eq("t3_stb0",  32'(a_stb),  32'd1);
        check_eq("t3_tone0", 32'(a_tone), 32'd5);
        check_eq("t3_ftw0",  a_ftw,       32'h0100_0500);
        watch(40);
        check_eq("t3_ntone",   32'(ntone),    32'd2);
        check_eq("t3_tone1",   32'(tones[0]), 32'd2);
        check_eq("t3_ftw1",    ftws[0],       32'h0100_0200);
        check_eq("t3_tone2",   32'(tones[1]), 32'd7);
        check_eq("t3_ftw2",    ftws[1],       32'h0100_0700);
        check_eq("t3_done_at", 32'(done_at),  32'd11);
        check_eq("t3_ur",      32'(a_ur),     32'd0);

        // T4 + T6: normal frame on small instance, tuning word wraps
        sel = 1'b1;
        b_write(3'd1); b_write(3'd3); b_write(3'd5); b_write(3'd7);
        check_eq("t4_txen_pre", 32'(b_txen), 32'd0);
        watch(40);
        check_eq("t4_ntone",   32'(ntone),    32'd4);
        check_eq("t4_tone0",   32'(tones[0]), 32'd1);
        check_eq("t4_tone3",   32'(tones[3]), 32'd7);
        check_eq("t6_ftw1",    ftws[0],       32'hFFFF_FFF8);
        check_eq("t6_ftw3",    ftws[1],       32'h0000_0008);
        check_eq("t6_ftw5",    ftws[2],       32'h0000_0018);
        check_eq("t6_ftw7",    ftws[3],       32'h0000_0028);
        check_eq("t4_done_at", 32'(done_at),  32'd16);
        check_eq("t4_ur0",     32'(b_ur),     32'd0);

        // Two symbols without msg_complete must not start a frame
        b_write(3'd2); b_write(3'd4);
        watch(20);
        check_eq("t4_nostart",  32'(ntone),    32'd0);
        check_eq("t4_nodone",   32'(done_at),  32'hFFFF_FFFF);
        check_eq("t4_cnt2",     32'(b_cnt),    32'd2);
        check_eq("t4_txen_off", 32'(b_txen),   32'd0);

        // Two more complete a frame
        b_write(3'd6); b_write(3'd0);
        watch(40);
        check_eq("t4_ntone2", 32'(ntone),    32'd4);
        check_eq("t4_f2_t0",  32'(tones[0]), 32'd2);
        check_eq("t4_f2_t3",  32'(tones[3]), 32'd0);
        check_eq("t4_done2",  32'(done_at),  32'd16);

        // Single msg pulse starts a short frame; msg_seen is cleared at
        // the start edge, so running dry is an underrun
        b_write(3'd6); b_write(3'd1);
        b_msg = 1'b1;
        @(negedge clk);
        b_msg = 1'b0;
        watch(20);
        check_eq("t4_ur_ntone", 32'(ntone),   32'd2);
        check_eq("t4_ur_nodone", 32'(done_at), 32'hFFFF_FFFF);
        check_eq("t4_ur_set",   32'(b_ur),    32'd1);
        check_eq("t4_ur_txen",  32'(b_txen),  32'd0);
        check_eq("t4_ur_ftw",   b_ftw,        B_BASE);
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
        check_eq("t4_ur_clr", 32'(b_ur), 32'd0);

        // T5: overflow
        for (int i = 0; i < 6; i++) b_write(3'(i));
        check_eq("t5_cnt_sat", 32'(b_cnt),  32'd4);
        check_eq("t5_ov_set",  32'(b_ov),   32'd1);
        check_eq("t5_txen",    32'(b_txen), 32'd1);
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
        check_eq("t5_ov_clr", 32'(b_ov), 32'd0);
        b_clr = 1'b1;
        b_vld = 1'b1;
        b_sym = 3'd7;
        @(negedge clk);
        b_clr = 1'b0;
        b_vld = 1'b0;
        check_eq("t5_set_wins", 32'(b_ov),  32'd1);
        check_eq("t5_cnt_hold", 32'(b_cnt), 32'd4);
        watch(40);
        check_eq("t5_ntone",   32'(ntone),    32'd3);
        check_eq("t5_tone1",   32'(tones[0]), 32'd1);
        check_eq("t5_tone3",   32'(tones[2]), 32'd3);
        check_eq("t5_done_at", 32'(done_at),  32'd12);
        check_eq("t5_left",    32'(b_cnt),    32'd1);

        // T1: reset in the middle of a transmission
        sel = 1'b0;
        a_write(3'd1); a_write(3'd2);
        a_msg = 1'b1;
        @(negedge clk);
        a_msg = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("t1_in_tx", 32'(a_txen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t1_txen", 32'(a_txen), 32'd0);
        check_eq("t1_cnt",  32'(a_cnt),  32'd0);
        check_eq("t1_ftw",  a_ftw,       A_BASE);
        check_eq("t1_tone", 32'(a_tone), 32'd0);
        check_eq("t1_b_ov", 32'(b_ov),   32'd0);
        check_eq("t1_b_cnt", 32'(b_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch(20);
        check_eq("t1_no_restart", 32'(ntone),  32'd0);
        check_eq("t1_cnt_after",  32'(a_cnt),  32'd0);
        check_eq("t1_txen_after", 32'(a_txen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
